sfp_slave_responder: RTL
========================

# sfp_slave_responder

Slave-end command responder for the BR MPS SFP link. It receives the two-beat command frames the master node sends over the 64-bit SFP AXI-Stream. It decodes and filters them by node ID, hands cmd/data to the local register side, and waits for completion. It then streams back an 11-beat response frame: header, 64-bit response word, and 9 telemetry words. It sits between the SFP transceiver stream ports and the local slave register/AXI4-Lite block, on the same 200 MHz clock.

## Interface
- P_TIMEOUT, 20000: cycles allowed in EXEC for i_done before a timeout response (100 µs at 200 MHz).
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- i_sfp_en  in  1  link enable; low aborts receive/exec.
- i_sfp_id  in  2  this node's ID.
- i_rx_tdata / i_rx_tvalid / o_rx_tready  in/in/out  64/1/1  command stream from SFP.
- o_tx_tdata / o_tx_tvalid / i_tx_tready  out/out/in  64/1/1  response stream to SFP.
- o_cmd, o_data  out  32 each  decoded command and data; held until next command.
- o_cmd_flag  out  1  one-cycle pulse: new command valid.
- i_done  in  1  local side finished; i_rsp sampled this cycle.
- i_rsp  in  64  response word.
- i_status, i_intl, i_c, i_v, i_dc_c, i_dc_v, i_phase_r, i_phase_s, i_phase_t  in  32 each  telemetry.
- o_busy  out  1  state ≠ S_IDLE.
- o_err_cnt  out  16  saturating protocol/timeout error count.

## Operation
- Command frame: beat0 = {8'hC3, 22'd0, id[1:0], cmd[31:0]}; beat1 = {8'hC4, 24'd0, data[31:0]}.
- Response frame, 11 beats: beat0 = {8'hD3, 22'd0, i_sfp_id, 16'd0, seq[15:0]}. beat1 = rsp[63:0]. Beats 2..10 = {8'hE0+k, 24'd0, tlm_k}, with k=0..8 in port order status…phase_t.
- States:
  - S_IDLE: o_rx_tready = i_sfp_en. On an accepted beat with byte7 ≠ C3: err+1, stay. With C3: latch cmd and id_match = (id == i_sfp_id), go to S_DATA.
  - S_DATA: o_rx_tready = 1. Accepted beat with byte7 ≠ C4: err+1, go to S_IDLE. With C4 and id_match: latch data, go to S_EXEC. With C4 and !id_match: discard, go to S_IDLE.
  - S_EXEC: o_rx_tready = 0. o_cmd_flag pulses on the entry cycle. The timer counts from 0.
    - i_done (sampled from the cycle after entry): snapshot i_rsp and all 9 telemetry inputs, go to S_SEND.
    - Timer reaches P_TIMEOUT-1: rsp = {32'hDEAD_DEAD, cmd}, telemetry snapshot, err+1, go to S_SEND.
  - S_SEND: beat index 0..10. On the last beat handshake: seq+1 (wraps FFFF→0), go to S_IDLE.
- i_sfp_en low in S_IDLE/S_DATA/S_EXEC: go to S_IDLE next cycle, no response, no err. In S_SEND the frame completes.
- i_done outside S_EXEC is ignored.
- o_err_cnt saturates at 16'hFFFF.

## Timing
- Reset values: all outputs 0; state S_IDLE; seq 0; err 0.
- o_cmd_flag is high exactly one cycle, the cycle after beat1's handshake. o_cmd/o_data are valid that cycle.
- First o_tx_tvalid is the cycle after i_done is sampled. Minimum frame length is 11 cycles with tready held high.
- AXIS rules:
  - o_tx_tvalid, once high, stays high with o_tx_tdata stable until i_tx_tready. tvalid never depends on tready.
  - Gaps in i_rx_tvalid between beat0 and beat1 are allowed, with no timeout.
- i_done on the same cycle as timer expiry: i_done wins, no err.
- Reset mid-operation: immediate return to reset values; a partial tx frame is truncated.

## Test plan
- i_sfp_id=1. Send {C3,…,id=1,cmd=0x0000_0010}, then {C4,…,data=0x1234_5678}. Assert i_done 3 cycles after the flag with i_rsp=0x0123_4567_89AB_CDEF and i_c=0x4120_0000 -> o_cmd_flag 1 cycle with cmd=0x10, data=0x12345678. Tx beats: 0xD300_0001_0000_0000, 0x0123456789ABCDEF, …, beat4 = 0xE200_0000_4120_0000.
- Same command with id=2 -> both beats accepted, no o_cmd_flag, no tx, err unchanged.
- beat0 byte7=0xC3, then beat1 byte7=0x00 -> err_cnt=1, state S_IDLE. A following beat with byte7=0xAA -> err_cnt=2.
- P_TIMEOUT=16, no i_done -> tx beat1 = 0xDEAD_DEAD_0000_0010, err_cnt+1, response starts 16 cycles after the flag.
- Tx with i_tx_tready toggled randomly -> 11 beats in order, data stable while stalled. Second response has seq=1. With seq preset by 65536 responses (or forced), seq wraps to 0.
- Deassert i_sfp_en in S_EXEC -> S_IDLE next cycle, no tx. Async reset asserted mid-S_SEND -> o_tx_tvalid=0 immediately, o_err_cnt=0.

Source files
------------

// File: rtl/sfp_slave_responder.sv
// Slave-side SFP command responder: accepts two-beat command frames, hands cmd/data to the
// local register side, then returns an 11-beat response frame (header, rsp word, telemetry).
module sfp_slave_responder #(
   parameter int unsigned P_TIMEOUT = 20000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sfp_en,
   input  logic [1:0]  i_sfp_id,
   input  logic [63:0] i_rx_tdata,
   input  logic        i_rx_tvalid,
   output logic        o_rx_tready,
   output logic [63:0] o_tx_tdata,
   output logic        o_tx_tvalid,
   input  logic        i_tx_tready,
   output logic [31:0] o_cmd,
   output logic [31:0] o_data,
   output logic        o_cmd_flag,
   input  logic        i_done,
   input  logic [63:0] i_rsp,
   input  logic [31:0] i_status,
   input  logic [31:0] i_intl,
   input  logic [31:0] i_c,
   input  logic [31:0] i_v,
   input  logic [31:0] i_dc_c,
   input  logic [31:0] i_dc_v,
   input  logic [31:0] i_phase_r,
   input  logic [31:0] i_phase_s,
   input  logic [31:0] i_phase_t,
   output logic        o_busy,
   output logic [15:0] o_err_cnt
);

   localparam int unsigned TimerW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(P_TIMEOUT - 1);
   localparam logic [3:0] LastBeat = 4'd10;

   typedef enum logic [1:0] {StIdle, StData, StExec, StSend} state_e;

   state_e             state_q, state_d;
   logic [31:0]        cmd_lat_q;
   logic               id_match_q;
   logic [31:0]        cmd_q, data_q;
   logic               flag_q;
   logic [TimerW-1:0]  timer_q;
   logic [63:0]        rsp_q;
   logic [31:0]        tlm_q [9];
   logic [31:0]        tlm_in [9];
   logic [1:0]         id_snap_q;
   logic [3:0]         beat_q;
   logic [15:0]        seq_q;
   logic [15:0]        err_q;

   logic rx_hs, tx_hs;
   logic err_inc, latch_cmd, go_exec, snap, timeout;
   logic [7:0] rx_tag;

   // Reserved header bits carry no information.
   logic unused_rx_bits;
   assign unused_rx_bits = ^i_rx_tdata[55:34];

   assign tlm_in[0] = i_status;
   assign tlm_in[1] = i_intl;
   assign tlm_in[2] = i_c;
   assign tlm_in[3] = i_v;
   assign tlm_in[4] = i_dc_c;
   assign tlm_in[5] = i_dc_v;
   assign tlm_in[6] = i_phase_r;
   assign tlm_in[7] = i_phase_s;
   assign tlm_in[8] = i_phase_t;

   assign rx_tag      = i_rx_tdata[63:56];
   assign rx_hs       = i_rx_tvalid && o_rx_tready;
   assign o_tx_tvalid = (state_q == StSend);
   assign tx_hs       = o_tx_tvalid && i_tx_tready;
   assign o_busy      = (state_q != StIdle);
   assign o_cmd       = cmd_q;
   assign o_data      = data_q;
   assign o_cmd_flag  = flag_q;
   assign o_err_cnt   = err_q;

   always_comb begin
      state_d     = state_q;
      o_rx_tready = 1'b0;
      err_inc     = 1'b0;
      latch_cmd   = 1'b0;
      go_exec     = 1'b0;
      snap        = 1'b0;
      timeout     = 1'b0;
      unique case (state_q)
         StIdle: begin
            o_rx_tready = i_sfp_en;
            if (rx_hs) begin
               if (rx_tag == 8'hC3) begin
                  latch_cmd = 1'b1;
                  state_d   = StData;
               end else begin
                  err_inc = 1'b1;
               end
            end
         end
         StData: begin
            o_rx_tready = 1'b1;
            if (!i_sfp_en) begin
               state_d = StIdle;
            end else if (rx_hs) begin
               if (rx_tag != 8'hC4) begin
                  err_inc = 1'b1;
                  state_d = StIdle;
               end else if (id_match_q) begin
                  go_exec = 1'b1;
                  state_d = StExec;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StExec: begin
            // flag_q marks the entry cycle, where i_done is not yet honoured.
            if (!i_sfp_en) begin
               state_d = StIdle;
            end else if (i_done && !flag_q) begin
               snap    = 1'b1;
               state_d = StSend;
            end else if (timer_q == TimerLast) begin
               snap    = 1'b1;
               timeout = 1'b1;
               err_inc = 1'b1;
               state_d = StSend;
            end
         end
         StSend: begin
            if (tx_hs && beat_q == LastBeat) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      o_tx_tdata = '0;
      if (state_q == StSend) begin
         if (beat_q == 4'd0) begin
            o_tx_tdata = {8'hD3, 22'd0, id_snap_q, 16'd0, seq_q};
         end else if (beat_q == 4'd1) begin
            o_tx_tdata = rsp_q;
         end
         for (int k = 0; k < 9; k++) begin
            if (beat_q == 4'(k + 2)) begin
               o_tx_tdata = {8'(8'hE0 + k), 24'd0, tlm_q[k]};
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= StIdle;
         cmd_lat_q  <= '0;
         id_match_q <= 1'b0;
         cmd_q      <= '0;
         data_q     <= '0;
         flag_q     <= 1'b0;
         timer_q    <= '0;
         rsp_q      <= '0;
         id_snap_q  <= '0;
         beat_q     <= '0;
         seq_q      <= '0;
         err_q      <= '0;
         for (int k = 0; k < 9; k++) begin
            tlm_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         flag_q  <= go_exec;
         if (latch_cmd) begin
            cmd_lat_q  <= i_rx_tdata[31:0];
            id_match_q <= (i_rx_tdata[33:32] == i_sfp_id);
         end
         if (go_exec) begin
            cmd_q   <= cmd_lat_q;
            data_q  <= i_rx_tdata[31:0];
            timer_q <= '0;
         end else if (state_q == StExec) begin
            timer_q <= timer_q + 1'b1;
         end
         if (snap) begin
            rsp_q     <= timeout ? {32'hDEAD_DEAD, cmd_q} : i_rsp;
            id_snap_q <= i_sfp_id;
            beat_q    <= '0;
            for (int k = 0; k < 9; k++) begin
               tlm_q[k] <= tlm_in[k];
            end
         end else if (tx_hs) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) begin
               seq_q <= seq_q + 1'b1;
            end
         end
         if (err_inc && err_q != 16'hFFFF) begin
            err_q <= err_q + 1'b1;
         end
      end
   end

endmodule
